fifo_load_sched: RTL and testbench

FIFO_LOAD_SCHED -- requirements
Module: fifo_load_sched

---
 rtl/fifo_load_sched.sv | 202 ++++++++++++++++++++
 tb/tb_fifo_load_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_load_sched.sv
// -----------------------------------------------------------------------------
// fifo_load_sched
// Queues trigger requests and starts FIFO load transfers one at a time. Each
// START is followed by a wait for the load engine's write-enable, the transfer
// itself and one guaranteed idle cycle before the next START can be issued.
//
// Parameters
//   DEPTH : maximum number of queued triggers (1..7)
//   TMO   : cycles to wait for write-enable after START before aborting (10-bit)
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_trig       : trigger request, one request per cycle high
//   i_nsamp      : last-sample index captured for the next transfer
//   i_clr_err    : synchronous clear of o_ovfl / o_tmo_err
//   i_wrena_in   : write-enable from the load engine, high during a transfer
//   o_start      : one-cycle START pulse to the load engine
//   o_samp_max   : sample limit, held for the whole transfer
//   o_busy       : high whenever the scheduler is not idle
//   o_pend       : number of queued, not yet issued triggers
//   o_evt_cnt    : number of START pulses issued (wraps)
//   o_ovfl       : sticky, a trigger was dropped on a full queue
//   o_tmo_err    : sticky, a transfer never raised write-enable in time
// -----------------------------------------------------------------------------
module fifo_load_sched #(
  parameter int DEPTH = 4,
  parameter int TMO   = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_trig,
  input  logic [6:0]  i_nsamp,
  input  logic        i_clr_err,
  input  logic        i_wrena_in,
  output logic        o_start,
  output logic [6:0]  o_samp_max,
  output logic        o_busy,
  output logic [2:0]  o_pend,
  output logic [11:0] o_evt_cnt,
  output logic        o_ovfl,
  output logic        o_tmo_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_WR = 3'd2,
    S_XFER    = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);
  localparam logic [9:0] TMO_L   = 10'(TMO);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_tmo_hit;
  logic [9:0]  r_tmo_cnt;
  logic        r_start;
  logic [6:0]  r_samp_max;
  logic        r_busy;
  logic [2:0]  r_pend;
  logic [2:0]  w_pend_nxt;
  logic [11:0] r_evt_cnt;
  logic        r_ovfl;
  logic        r_tmo_err;
  logic        w_issue;
  logic        w_accept;
  logic        w_drop;

  assign w_issue = (r_state == S_ISSUE);

  // A trigger on a full queue still fits when the issue frees a slot that cycle.
  assign w_accept = i_trig && ((r_pend < DEPTH_L) || w_issue);
  assign w_drop   = i_trig && !w_accept;

  // Next-state decode; the timeout compare uses >= so TMO=0 aborts at once.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 3'd0) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (i_wrena_in) begin
          w_state_nxt = S_XFER;
        end else if (r_tmo_cnt >= TMO_L) begin
          w_state_nxt = S_IDLE;
          w_tmo_hit   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT_WR;
        end
      end
      S_XFER: begin
        if (!i_wrena_in) begin
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Queue occupancy: an accept and an issue in the same cycle cancel out.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_accept && !w_issue) begin
      w_pend_nxt = r_pend + 3'd1;
    end else if (!w_accept && w_issue) begin
      w_pend_nxt = r_pend - 3'd1;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // State register and timeout counter; the count is 0 in ISSUE, so the
  // abort lands TMO cycles after the START cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == S_ISSUE) begin
        r_tmo_cnt <= 10'd0;
      end else if ((r_state == S_ISSUE) || (r_state == S_WAIT_WR)) begin
        r_tmo_cnt <= r_tmo_cnt + 10'd1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
    end
  end

  // Registered START/BUSY derived from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= (w_state_nxt == S_ISSUE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Transfer bookkeeping: sample limit captured and event counted on issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp_max <= 7'd0;
      r_evt_cnt  <= 12'd0;
      r_pend     <= 3'd0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_issue) begin
        r_samp_max <= i_nsamp;
        r_evt_cnt  <= r_evt_cnt + 12'd1;
      end
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovfl    <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovfl <= 1'b1;
      end else if (i_clr_err) begin
        r_ovfl <= 1'b0;
      end
      if (w_tmo_hit) begin
        r_tmo_err <= 1'b1;
      end else if (i_clr_err) begin
        r_tmo_err <= 1'b0;
      end
    end
  end

  assign o_start    = r_start;
  assign o_samp_max = r_samp_max;
  assign o_busy     = r_busy;
  assign o_pend     = r_pend;
  assign o_evt_cnt  = r_evt_cnt;
  assign o_ovfl     = r_ovfl;
  assign o_tmo_err  = r_tmo_err;

endmodule

// File: tb/tb_fifo_load_sched.sv
// Bench for fifo_load_sched: transaction-timing reference model, scoreboard
// queue of expected START events, and a separate monitor that pops them.
module tb_fifo_load_sched;
  localparam int DEPTH = 4;
  localparam int TMO   = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_trig = 1'b0;
  logic [6:0]  i_nsamp = 7'd0;
  logic        i_clr_err = 1'b0;
  logic        i_wrena_in = 1'b0;
  logic        o_start;
  logic [6:0]  o_samp_max;
  logic        o_busy;
  logic [2:0]  o_pend;
  logic [11:0] o_evt_cnt;
  logic        o_ovfl;
  logic        o_tmo_err;

  fifo_load_sched #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(i_trig), .i_nsamp(i_nsamp),
    .i_clr_err(i_clr_err), .i_wrena_in(i_wrena_in), .o_start(o_start),
    .o_samp_max(o_samp_max), .o_busy(o_busy), .o_pend(o_pend),
    .o_evt_cnt(o_evt_cnt), .o_ovfl(o_ovfl), .o_tmo_err(o_tmo_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          at;
    logic [6:0]  samp;
    logic [11:0] evt;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: queue length, sticky flags, and the timing of the
  // current transfer expressed as cycle numbers.
  int         m_p, m_evt, m_issue_at, m_wait_from, m_free_at, m_acc_total;
  bit         m_ovfl, m_tmo, m_wait, m_move;
  logic [6:0] m_samp;
  int         wr_on, wr_off;
  logic [6:0] ns_cur = 7'd0;

  // Stimulus knobs
  bit         noise_en = 1'b0;
  bit         force_plan = 1'b0;
  int         f_d = 0, f_l = 1;
  bit         f_tmo = 1'b0;
  bit         fix_ns_en = 1'b0;
  logic [6:0] fix_ns = 7'd0;
  bit         mon_en = 1'b0;
  int         starts_seen = 0;
  int         obs_pmax = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_evt = 0; m_issue_at = -1; m_wait_from = 0; m_free_at = 0;
    m_acc_total = 0; m_ovfl = 0; m_tmo = 0; m_wait = 0; m_move = 0;
    m_samp = 7'd0; wr_on = 0; wr_off = 0;
  endtask

  function automatic bit model_idle(input int c);
    return !m_wait && !m_move && (c >= m_free_at) && (m_issue_at != c);
  endfunction

  // One cycle: compare outputs with the model, drive inputs, advance model.
  task automatic step(input bit trig, input bit clr);
    int c; bit idle_now, wr, iss, acc, drop, tmo_set;
    logic [6:0] ns_next; int d, l; bit t;
    c = cyc;
    idle_now = model_idle(c);
    chk("busy", int'(o_busy), idle_now ? 0 : 1);
    chk("pend", int'(o_pend), m_p);
    chk("ovfl", int'(o_ovfl), int'(m_ovfl));
    chk("tmo_err", int'(o_tmo_err), int'(m_tmo));
    chk("evt_cnt", int'(o_evt_cnt), m_evt);
    chk("samp_max", int'(o_samp_max), int'(m_samp));
    if (int'(o_pend) > obs_pmax) obs_pmax = int'(o_pend);
    if (m_wait || m_move) wr = (c >= wr_on) && (c < wr_off);
    else if (noise_en) wr = 1'($urandom_range(0, 1));
    else wr = 1'b0;
    ns_next = fix_ns_en ? fix_ns : 7'($urandom_range(0, 127));
    i_trig = trig; i_nsamp = ns_cur; i_clr_err = clr; i_wrena_in = wr;
    iss = (m_issue_at == c);
    tmo_set = 1'b0;
    if (iss) begin
      m_evt = (m_evt + 1) % 4096; m_samp = ns_cur; m_wait = 1; m_wait_from = c;
    end else if (m_wait) begin
      if (wr) begin m_wait = 0; m_move = 1; end
      else if (c - m_wait_from >= TMO) begin m_wait = 0; tmo_set = 1; m_free_at = c + 1; end
    end else if (m_move) begin
      if (!wr) begin m_move = 0; m_free_at = c + 2; end
    end else if (idle_now && m_p > 0) begin
      m_issue_at = c + 1;
      if (force_plan) begin d = f_d; l = f_l; t = f_tmo; end
      else begin
        d = $urandom_range(0, 4); l = $urandom_range(1, 6);
        t = ($urandom_range(0, 15) == 0);
      end
      if (t) begin wr_on = 32'h7fffffff; wr_off = 32'h7fffffff; end
      else begin wr_on = c + 2 + d; wr_off = wr_on + l; end
      sb_q.push_back('{at: c + 1, samp: ns_next, evt: 12'(m_evt)});
    end
    acc = trig && ((m_p < DEPTH) || iss);
    drop = trig && !acc;
    m_p = m_p + (acc ? 1 : 0) - (iss ? 1 : 0);
    if (acc) m_acc_total++;
    if (drop) m_ovfl = 1; else if (clr) m_ovfl = 0;
    if (tmo_set) m_tmo = 1; else if (clr) m_tmo = 0;
    ns_cur = ns_next;
  endtask

  task automatic tick(input bit trig, input bit clr);
    @(negedge clk);
    step(trig, clr);
  endtask

  task automatic drain();
    int n = 0;
    while (!(m_p == 0 && model_idle(cyc + 1) && m_issue_at <= cyc) && n < 400) begin
      tick(1'b0, 1'b0); n++;
    end
    if (n >= 400) chk("drain_timeout", n, 0);
    tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; i_trig = 1'b0; i_wrena_in = 1'b0; i_clr_err = 1'b0;
    #1;
    chk("rst_start", int'(o_start), 0);
    chk("rst_samp", int'(o_samp_max), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_pend", int'(o_pend), 0);
    chk("rst_evt", int'(o_evt_cnt), 0);
    chk("rst_ovfl", int'(o_ovfl), 0);
    chk("rst_tmo", int'(o_tmo_err), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a START.
  initial begin
    exp_t e;
    bit sc;
    logic [6:0] se;
    sc = 1'b0; se = 7'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) sc = 1'b0;
      else begin
        if (sc) begin chk("samp_after_start", int'(o_samp_max), int'(se)); sc = 1'b0; end
        if (o_start) begin
          starts_seen++;
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL start_unexpected: got START, expected none (cycle %0d)", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("start_cycle", cyc, e.at);
            chk("start_evt", int'(o_evt_cnt), int'(e.evt));
            se = e.samp; sc = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    model_reset();
    do_reset();
    mon_en = 1'b1;

    // Single transfer, NSAMP=7, write-enable high 3..50 cycles after trigger
    force_plan = 1; f_d = 0; f_l = 48; f_tmo = 0;
    fix_ns_en = 1; fix_ns = 7'd7;
    s0 = starts_seen;
    tick(1'b1, 1'b0);
    repeat (60) tick(1'b0, 1'b0);
    chk("single_starts", starts_seen - s0, 1);
    chk("single_evt", int'(o_evt_cnt), 1);
    fix_ns_en = 0;

    // Six back-to-back triggers: one dropped, five transfers
    f_l = 2; s0 = starts_seen; obs_pmax = 0;
    repeat (6) tick(1'b1, 1'b0);
    drain();
    chk("burst_starts", starts_seen - s0, 5);
    chk("burst_pmax", obs_pmax, 4);
    chk("burst_ovfl", int'(o_ovfl), 1);

    // Timeout with write-enable never raised
    tick(1'b0, 1'b1);
    f_tmo = 1;
    tick(1'b1, 1'b0);
    drain();
    chk("tmo_flag", int'(o_tmo_err), 1);
    chk("tmo_pend", int'(o_pend), 0);
    f_tmo = 0;
    tick(1'b0, 1'b1);

    // Full queue with a trigger on every issue cycle: accepted, no overflow
    f_d = 0; f_l = 25;
    repeat (5) tick(1'b1, 1'b0);
    repeat (150) tick(m_issue_at == cyc, 1'b0);
    drain();
    chk("full_issue_ovfl", int'(o_ovfl), 0);

    // Reset during a transfer with three triggers pending
    f_l = 30;
    repeat (4) tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    chk("pre_reset_pend", int'(o_pend), 3);
    chk("pre_reset_busy", int'(o_busy), 1);
    do_reset();
    s0 = starts_seen;
    repeat (20) tick(1'b0, 1'b0);
    chk("post_reset_starts", starts_seen - s0, 0);

    // Randomized traffic with noise on write-enable outside transfers
    force_plan = 0; noise_en = 1;
    repeat (3000) tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
    noise_en = 0;
    drain();

    // Event counter wrap after 4096 transfers
    do_reset();
    force_plan = 1; f_d = 0; f_l = 1; f_tmo = 0;
    s0 = starts_seen;
    while (m_acc_total < 4096 && cyc < 50000) tick(1'b1, 1'b0);
    drain();
    chk("wrap_starts", starts_seen - s0, 4096);
    chk("wrap_evt", int'(o_evt_cnt), 0);

    // Clear coinciding with a dropped trigger keeps the overflow flag
    f_l = 20;
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("clr_vs_drop_ovfl", int'(o_ovfl), 1);
    drain();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("clr_ovfl", int'(o_ovfl), 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
